// File: rtl/password_writer.sv
// Two-pass entry of a new BCD password; commits only when the confirm pass matches the first.
// Latency: final confirm press at edge N -> pwd_commit during the next cycle -> pwd_out at the edge after.
// Backpressure: none; presses in COMMIT/ERROR or with prog_en low are dropped, idle entry times out.
module password_writer #(
    parameter int                      NUM_DIGITS     = 4,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PWD    = 16'h4791,
    parameter int                      TIMEOUT_CYCLES = 50_000_000,
    parameter int                      ERR_CYCLES     = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_en,
    input  logic                      button_press,
    input  logic [3:0]                toggle_switch,
    output logic [4*NUM_DIGITS-1:0]   pwd_out,
    output logic                      pwd_commit,
    output logic                      prog_busy,
    output logic [3:0]                entry_count,
    output logic                      ok_LED,
    output logic                      err_LED
);

    localparam int         TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         ER_W = $clog2(ERR_CYCLES + 1);
    localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CONFIRM, COMMIT, ERROR} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              buf_a_q [NUM_DIGITS];
    logic [3:0]              buf_a_d [NUM_DIGITS];
    logic [3:0]              buf_b_q [NUM_DIGITS];
    logic [3:0]              buf_b_d [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] pwd_q, pwd_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [TO_W-1:0]         idle_q, idle_d;
    logic [ER_W-1:0]         err_q, err_d;
    logic                    ok_q, ok_d;
    logic                    digit_bad;
    logic                    match;
    logic                    to_err;
    logic                    abort;

    always_comb begin
        state_d   = state_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        pwd_d     = pwd_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        err_d     = err_q;
        ok_d      = ok_q;
        to_err    = 1'b0;
        abort     = 1'b0;
        digit_bad = toggle_switch > 4'd9;

        // The last confirm digit is still on the switches, so it is compared directly.
        match = (toggle_switch == buf_a_q[NUM_DIGITS-1]);
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (buf_b_q[i] != buf_a_q[i]) match = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (button_press || !prog_en) ok_d = 1'b0;
                if (prog_en && button_press) begin
                    if (digit_bad) begin
                        to_err = 1'b1;
                    end else begin
                        buf_a_d[0] = toggle_switch;
                        cnt_d      = 4'd1;
                        idle_d     = '0;
                        state_d    = ENTRY;
                    end
                end
            end
            ENTRY, CONFIRM: begin
                if (!prog_en) begin
                    abort = 1'b1;
                end else if (button_press) begin
                    if (digit_bad) begin
                        to_err = 1'b1;
                    end else begin
                        idle_d = '0;
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (cnt_q == 4'(i)) begin
                                if (state_q == ENTRY) buf_a_d[i] = toggle_switch;
                                else                  buf_b_d[i] = toggle_switch;
                            end
                        end
                        if (cnt_q == LAST) begin
                            cnt_d = '0;
                            if (state_q == ENTRY) state_d = CONFIRM;
                            else if (match)       state_d = COMMIT;
                            else                  to_err  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    to_err = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            COMMIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    pwd_d[4*(NUM_DIGITS-1-i) +: 4] = buf_a_q[i];
                end
                ok_d    = 1'b1;
                buf_a_d = '{default: '0};
                buf_b_d = '{default: '0};
                state_d = IDLE;
            end
            ERROR: begin
                if (err_q == '0) state_d = IDLE;
                else             err_d   = err_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (to_err || abort) begin
            state_d = to_err ? ERROR : IDLE;
            cnt_d   = '0;
            idle_d  = '0;
            buf_a_d = '{default: '0};
            buf_b_d = '{default: '0};
        end
        if (to_err) err_d = ER_W'(ERR_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_a_q <= '{default: '0};
            buf_b_q <= '{default: '0};
            pwd_q   <= DEFAULT_PWD;
            cnt_q   <= '0;
            idle_q  <= '0;
            err_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            pwd_q   <= pwd_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    assign pwd_out     = pwd_q;
    assign pwd_commit  = (state_q == COMMIT);
    assign prog_busy   = (state_q == ENTRY) || (state_q == CONFIRM);
    assign entry_count = cnt_q;
    assign ok_LED      = ok_q;
    assign err_LED     = (state_q == ERROR);

endmodule

// File: tb/tb_password_writer.sv
// Random and directed two-pass password entry against a digit-list reference model,
// with expected outputs queued per cycle and checked by an independent monitor.
module tb_password_writer;

    localparam int ND = 4;
    localparam int TO = 16;
    localparam int EC = 8;

    localparam int M_IDLE   = 0;
    localparam int M_FIRST  = 1;
    localparam int M_SECOND = 2;
    localparam int M_COMMIT = 3;
    localparam int M_ERROR  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_en = 1'b0;
    logic        button_press = 1'b0;
    logic [3:0]  toggle_switch = 4'd0;
    logic [15:0] pwd_out;
    logic        pwd_commit, prog_busy, ok_LED, err_LED;
    logic [3:0]  entry_count;

    password_writer #(
        .NUM_DIGITS(ND), .DEFAULT_PWD(16'h4791),
        .TIMEOUT_CYCLES(TO), .ERR_CYCLES(EC)
    ) dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .button_press(button_press),
        .toggle_switch(toggle_switch), .pwd_out(pwd_out), .pwd_commit(pwd_commit),
        .prog_busy(prog_busy), .entry_count(entry_count), .ok_LED(ok_LED), .err_LED(err_LED)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pwd;
        logic        commit;
        logic        busy;
        logic [3:0]  cnt;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: the password is just two lists of typed digits.
    int          mode = M_IDLE;
    int          first_q[$];
    int          second_q[$];
    logic [15:0] m_pwd = 16'h4791;
    bit          m_ok = 1'b0;
    int          m_idle = 0;
    int          m_errleft = 0;
    bit          cur_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic go_error();
        mode = M_ERROR;
        m_errleft = EC;
        first_q.delete();
        second_q.delete();
    endtask

    task automatic model_step(input bit r, input bit en, input bit p, input int d);
        bit same;
        int acc;
        if (!r) begin
            mode = M_IDLE; m_pwd = 16'h4791; m_ok = 1'b0; m_idle = 0; m_errleft = 0;
            first_q.delete(); second_q.delete();
            return;
        end
        case (mode)
            M_IDLE: begin
                if (p || !en) m_ok = 1'b0;
                if (en && p) begin
                    if (d > 9) go_error();
                    else begin first_q.push_back(d); mode = M_FIRST; m_idle = 0; end
                end
            end
            M_FIRST, M_SECOND: begin
                if (!en) begin
                    mode = M_IDLE; first_q.delete(); second_q.delete();
                end else if (p) begin
                    if (d > 9) go_error();
                    else begin
                        m_idle = 0;
                        if (mode == M_FIRST) begin
                            first_q.push_back(d);
                            if (first_q.size() == ND) mode = M_SECOND;
                        end else begin
                            second_q.push_back(d);
                            if (second_q.size() == ND) begin
                                same = 1'b1;
                                for (int i = 0; i < ND; i++) if (first_q[i] != second_q[i]) same = 1'b0;
                                if (same) mode = M_COMMIT; else go_error();
                            end
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) go_error();
                end
            end
            M_COMMIT: begin
                acc = 0;
                foreach (first_q[i]) acc = acc * 16 + first_q[i];
                m_pwd = 16'(acc);
                m_ok = 1'b1;
                mode = M_IDLE;
                first_q.delete(); second_q.delete();
            end
            default: begin
                m_errleft--;
                if (m_errleft == 0) mode = M_IDLE;
            end
        endcase
    endtask

    task automatic cyc(input bit r, input bit en, input bit p, input int d);
        exp_t e;
        @(negedge clk);
        rst = r; prog_en = en; button_press = p; toggle_switch = 4'(d);
        model_step(r, en, p, d);
        e.pwd    = m_pwd;
        e.commit = (mode == M_COMMIT);
        e.busy   = (mode == M_FIRST) || (mode == M_SECOND);
        e.cnt    = (mode == M_FIRST) ? 4'(first_q.size()) : (mode == M_SECOND) ? 4'(second_q.size()) : 4'd0;
        e.ok     = m_ok;
        e.err    = (mode == M_ERROR);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, cur_en, 0, 0);
    endtask

    task automatic press(input int d, input int gap);
        cyc(1, cur_en, 1, d);
        idle(gap);
    endtask

    // Monitor: compares every post-edge output against the queued expectation.
    int err_run = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pwd_out",     32'(pwd_out),     32'(e.pwd));
                check("pwd_commit",  32'(pwd_commit),  32'(e.commit));
                check("prog_busy",   32'(prog_busy),   32'(e.busy));
                check("entry_count", 32'(entry_count), 32'(e.cnt));
                check("ok_LED",      32'(ok_LED),      32'(e.ok));
                check("err_LED",     32'(err_LED),     32'(e.err));
            end
            if (!rst) err_run = 0;
            else if (err_LED) err_run++;
            else if (err_run != 0) begin
                check("err_duration", 32'(err_run), 32'(EC));
                err_run = 0;
            end
        end
    end

    initial begin
        int pw[ND];
        int kind, d, gap;
        cur_en = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        idle(10);

        // Program 1234.
        foreach (pw[i]) pw[i] = i + 1;
        for (int k = 0; k < 2 * ND; k++) press(pw[k % ND], 1);
        idle(3);

        // Confirm mismatch on the last digit.
        press(5, 0); press(6, 0); press(7, 0); press(8, 0);
        press(5, 0); press(6, 0); press(7, 0); press(9, 0);
        idle(12);

        // Abort coinciding with a press, then a press while disabled.
        press(2, 0); press(3, 0);
        cyc(1, 0, 1, 4);
        cyc(1, 0, 1, 5);
        idle(3);
        cur_en = 1'b1;
        idle(1);

        // Invalid digit in ENTRY, then a timeout.
        press(1, 0); press(11, 0); idle(12);
        press(1, 20); idle(10);

        // Commit 9876, then reset in the middle of a new entry.
        foreach (pw[i]) pw[i] = 9 - i;
        for (int k = 0; k < 2 * ND; k++) press(pw[k % ND], 0);
        idle(2);
        press(1, 0); press(2, 0);
        cyc(0, 1, 0, 0);
        idle(3);

        for (int ep = 0; ep < 60; ep++) begin
            foreach (pw[i]) pw[i] = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            cur_en = 1'b1;
            idle(1);
            for (int k = 0; k < 2 * ND; k++) begin
                d = pw[k % ND];
                gap = $urandom_range(0, 3);
                if (kind == 5 && k == 2 * ND - 1) d = (d + 1) % 10;
                if (kind == 6 && k == ND) d = (d + 3) % 10;
                if (kind == 7 && k == 2) d = $urandom_range(10, 15);
                if (kind == 8 && k == 5) gap = TO + 2;
                if (kind == 9 && k == 4) begin
                    if ($urandom_range(0, 1) == 0) cur_en = 1'b0;
                    else begin cyc(0, 1, 0, 0); continue; end
                end
                press(d, gap);
            end
            cur_en = 1'b1;
            idle(30);
        end

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
